// File: rtl/mouse_tracker.sv
// Mouse input conditioner: synchronised/debounced button plus a clamped absolute X position
// fed by signed deltas. Define MOUSE_TRACKER_WRAP_EN for modulo position arithmetic instead of clamping.
module mouse_tracker #(
  parameter int WIDTH           = 16,
  parameter int DELTA_WIDTH     = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset_,
  input  logic                   button_raw_,
  input  logic                   delta_valid,
  output logic                   delta_ready,
  input  logic [DELTA_WIDTH-1:0] delta_x,
  output logic                   mouse_pressed_,
  output logic [WIDTH-1:0]       mouse_x,
  output logic                   click
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, APPLY = 1'b1} state_t;

  logic          sync1, sync2;
  logic [CW-1:0] count;

  state_t                 state, next_state;
  logic                   load, apply;
  logic [DELTA_WIDTH-1:0] held;
  logic [WIDTH-1:0]       new_x;

  // Button path: two-flop synchroniser, then a level change is accepted only
  // after DEBOUNCE_CYCLES consecutive differing synced samples.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      sync1          <= 1'b1;
      sync2          <= 1'b1;
      count          <= '0;
      mouse_pressed_ <= 1'b1;
      click          <= 1'b0;
    end else begin
      sync1 <= button_raw_;
      sync2 <= sync1;
      click <= 1'b0;
      if (sync2 == mouse_pressed_) begin
        count <= '0;
      end else if (count == CNT_MAX) begin
        mouse_pressed_ <= sync2;
        count          <= '0;
        click          <= ~sync2;
      end else begin
        count <= count + CW'(1);
      end
    end
  end

  always_comb begin
    next_state = state;
    load       = 1'b0;
    apply      = 1'b0;
    unique case (state)
      IDLE: begin
        if (delta_valid) begin
          next_state = APPLY;
          load       = 1'b1;
        end
      end
      APPLY: begin
        next_state = IDLE;
        apply      = 1'b1;
      end
      default: next_state = IDLE;
    endcase
  end

`ifdef MOUSE_TRACKER_WRAP_EN
  logic [WIDTH-1:0] delta_ext;
  always_comb begin
    delta_ext = {{(WIDTH-DELTA_WIDTH){held[DELTA_WIDTH-1]}}, held};
    new_x     = mouse_x + delta_ext;
  end
`else
  logic [WIDTH+1:0] delta_ext;
  logic [WIDTH+1:0] sum;
  // Two guard bits: bit WIDTH+1 flags a negative result, bit WIDTH an overflow.
  always_comb begin
    delta_ext = {{(WIDTH+2-DELTA_WIDTH){held[DELTA_WIDTH-1]}}, held};
    sum       = {2'b00, mouse_x} + delta_ext;
    if (sum[WIDTH+1])
      new_x = '0;
    else if (sum[WIDTH])
      new_x = '1;
    else
      new_x = sum[WIDTH-1:0];
  end
`endif

  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      state       <= IDLE;
      delta_ready <= 1'b1;
      held        <= '0;
      mouse_x     <= '0;
    end else begin
      state       <= next_state;
      delta_ready <= (next_state == IDLE);
      if (load)
        held <= delta_x;
      if (apply)
        mouse_x <= new_x;
    end
  end

endmodule

// File: tb/tb_mouse_tracker.sv
// Directed bench for mouse_tracker: reset, delta handshake, clamp/wrap boundaries, debounce, reset in APPLY.
module tb_mouse_tracker;

  logic        clock = 1'b0;
  logic        reset_;
  logic        button_raw_;
  logic        delta_valid;
  logic        delta_ready;
  logic [7:0]  delta_x;
  logic        mouse_pressed_;
  logic [15:0] mouse_x;
  logic        click;

  int checks = 0;
  int passes = 0;

  mouse_tracker #(.WIDTH(16), .DELTA_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .clock          (clock),
    .reset_         (reset_),
    .button_raw_    (button_raw_),
    .delta_valid    (delta_valid),
    .delta_ready    (delta_ready),
    .delta_x        (delta_x),
    .mouse_pressed_ (mouse_pressed_),
    .mouse_x        (mouse_x),
    .click          (click)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    assert (act === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_ = 1'b0;
    tick();
    tick();
    reset_ = 1'b1;
  endtask

  // Full handshake: accept on the first edge, apply on the second.
  task automatic send(input logic [7:0] d);
    delta_valid = 1'b1;
    delta_x     = d;
    tick();
    delta_valid = 1'b0;
    tick();
  endtask

  initial begin
    reset_      = 1'b0;
    button_raw_ = 1'b1;
    delta_valid = 1'b0;
    delta_x     = 8'd0;
    tick();
    tick();
    reset_ = 1'b1;
    tick();
    check("rst_mouse_x", 32'(mouse_x), 32'd0);
    check("rst_pressed", 32'(mouse_pressed_), 32'd1);
    check("rst_click", 32'(click), 32'd0);
    check("rst_ready", 32'(delta_ready), 32'd1);

    // +5 with valid held through APPLY: applied once only
    delta_valid = 1'b1;
    delta_x     = 8'd5;
    tick();
    check("acc_ready_low", 32'(delta_ready), 32'd0);
    check("acc_x_unchanged", 32'(mouse_x), 32'd0);
    tick();
    check("apply_x5", 32'(mouse_x), 32'd5);
    check("apply_ready_high", 32'(delta_ready), 32'd1);
    delta_valid = 1'b0;
    tick();
    tick();
    check("held_valid_once", 32'(mouse_x), 32'd5);

    send(8'hFE);
    check("x_to_3", 32'(mouse_x), 32'd3);
    send(8'hF6);
`ifdef MOUSE_TRACKER_WRAP_EN
    check("under_minus10", 32'(mouse_x), 32'd65529);
`else
    check("under_minus10", 32'(mouse_x), 32'd0);
`endif

    do_reset();
    send(8'h80);
`ifdef MOUSE_TRACKER_WRAP_EN
    check("under_minus128", 32'(mouse_x), 32'd65408);
`else
    check("under_minus128", 32'(mouse_x), 32'd0);
`endif

    // Climb to 65530: 516 * 127 = 65532, then -2
    do_reset();
    for (int i = 0; i < 516; i++) send(8'd127);
    check("climb_65532", 32'(mouse_x), 32'd65532);
    send(8'hFE);
    check("x_65530", 32'(mouse_x), 32'd65530);
    send(8'd127);
`ifdef MOUSE_TRACKER_WRAP_EN
    check("over_plus127", 32'(mouse_x), 32'd121);
`else
    check("over_plus127", 32'(mouse_x), 32'd65535);
`endif

    // Short bounce: 3 clocks low is rejected
    do_reset();
    button_raw_ = 1'b0;
    tick();
    tick();
    tick();
    button_raw_ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("bounce_pressed", 32'(mouse_pressed_), 32'd1);
      check("bounce_click", 32'(click), 32'd0);
      tick();
    end

    // Long press: level flips after the 6th edge, click for that cycle only
    button_raw_ = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      check("press_pressed", 32'(mouse_pressed_), (i >= 6) ? 32'd0 : 32'd1);
      check("press_click", 32'(click), (i == 6) ? 32'd1 : 32'd0);
    end
    button_raw_ = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("release_pressed", 32'(mouse_pressed_), (i >= 6) ? 32'd1 : 32'd0);
      check("release_click", 32'(click), 32'd0);
    end

    // Async reset while +20 sits in APPLY
    send(8'd3);
    check("pre_rst_x3", 32'(mouse_x), 32'd3);
    delta_valid = 1'b1;
    delta_x     = 8'd20;
    tick();
    delta_valid = 1'b0;
    check("apply_pending_ready", 32'(delta_ready), 32'd0);
    #2;
    reset_ = 1'b0;
    #1;
    check("async_x_clear", 32'(mouse_x), 32'd0);
    check("async_ready_set", 32'(delta_ready), 32'd1);
    tick();
    reset_ = 1'b1;
    tick();
    tick();
    tick();
    check("no_late_update", 32'(mouse_x), 32'd0);

    // Concurrent press and delta
    button_raw_ = 1'b0;
    delta_valid = 1'b1;
    delta_x     = 8'd7;
    for (int i = 1; i <= 7; i++) begin
      tick();
      delta_valid = 1'b0;
      if (i == 1) check("conc_ready_low", 32'(delta_ready), 32'd0);
      if (i == 2) check("conc_x7", 32'(mouse_x), 32'd7);
      check("conc_pressed", 32'(mouse_pressed_), (i >= 6) ? 32'd0 : 32'd1);
      check("conc_click", 32'(click), (i == 6) ? 32'd1 : 32'd0);
    end
    button_raw_ = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    check("conc_released", 32'(mouse_pressed_), 32'd1);
    check("conc_x_kept", 32'(mouse_x), 32'd7);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
